// File: rtl/posit_defines_pkg.sv
// rtl/posit_defines_pkg.sv - shared posit<4,0> constants and types
package posit_defines;

    localparam int QUIRE_FRAC_BITS_4_0 = 4;

    // Lower bound of each magnitude code, in quire LSBs (1/16 units).
    localparam int P40_THR_010 = 6;
    localparam int P40_THR_011 = 11;
    localparam int P40_THR_100 = 14;
    localparam int P40_THR_101 = 21;
    localparam int P40_THR_110 = 28;
    localparam int P40_THR_111 = 49;

    localparam logic [3:0] POSIT_4_0_NAR  = 4'b1000;
    localparam logic [3:0] POSIT_4_0_ZERO = 4'b0000;

    typedef logic [2:0] p40_code_t;

endpackage

// File: rtl/posit_4_0_round_encode.sv
// rtl/posit_4_0_round_encode.sv - unsigned quire magnitude to rounded posit<4,0> magnitude code
module posit_4_0_round_encode
    import posit_defines::*;
#(
    parameter int MAG_W = 20
) (
    input  logic [MAG_W-1:0] mag_i,
    output p40_code_t        code_o
);

    // Thresholds already fold in ties-to-even, so nonzero never drops to 000.
    always_comb begin
        code_o = 3'b000;
        if (mag_i >= MAG_W'(P40_THR_111))      code_o = 3'b111;
        else if (mag_i >= MAG_W'(P40_THR_110)) code_o = 3'b110;
        else if (mag_i >= MAG_W'(P40_THR_101)) code_o = 3'b101;
        else if (mag_i >= MAG_W'(P40_THR_100)) code_o = 3'b100;
        else if (mag_i >= MAG_W'(P40_THR_011)) code_o = 3'b011;
        else if (mag_i >= MAG_W'(P40_THR_010)) code_o = 3'b010;
        else if (mag_i != '0)                  code_o = 3'b001;
    end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// rtl/quire_to_posit_4_0.sv - three-stage quire to posit<4,0> converter with sticky window NaR
module quire_to_posit_4_0
    import posit_defines::*;
#(
    parameter bit ONLY_EOW   = 1'b1,
    parameter int QUIRE_SIZE = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rts_i,
    output logic                  rtr_o,
    input  logic                  sow_i,
    input  logic                  eow_i,
    input  logic [QUIRE_SIZE-1:0] data_i,
    input  logic                  sign_i,
    input  logic                  zero_i,
    input  logic                  NaR_i,
    input  logic                  rtr_i,
    output logic                  rts_o,
    output logic                  sow_o,
    output logic                  eow_o,
    output logic [3:0]            posit_o,
    output logic                  NaR_o,
    output logic                  zero_o,
    output logic                  sign_o
);

    logic process_en;
    logic accept;

    logic                  nar_acc_q, nar_acc_d;
    logic                  s1_valid_q, s1_sign_q, s1_zero_q, s1_nar_q, s1_sow_q, s1_eow_q;
    logic [QUIRE_SIZE-1:0] s1_mag_q;
    logic                  s2_valid_q, s2_sign_q, s2_zero_q, s2_nar_q, s2_sow_q, s2_eow_q;
    p40_code_t             s2_code_q;
    logic                  s3_valid_q, s3_sow_q, s3_eow_q, s3_nar_q;
    logic [3:0]            s3_posit_q;

    logic [QUIRE_SIZE-1:0] mag_d;
    logic                  nar_cap_d;
    p40_code_t             code_d;
    logic [3:0]            pos_mag;
    logic [3:0]            posit_d;

    assign process_en = rtr_i | ~rts_o;
    assign rtr_o      = process_en;
    assign accept     = rts_i & process_en;

    // Most negative quire wraps to 2^(N-1), which is still the correct unsigned magnitude.
    assign mag_d     = data_i[QUIRE_SIZE-1] ? (~data_i + QUIRE_SIZE'(1)) : data_i;
    assign nar_cap_d = NaR_i | (~sow_i & nar_acc_q);
    assign nar_acc_d = sow_i ? NaR_i : (nar_acc_q | NaR_i);

    posit_4_0_round_encode #(.MAG_W(QUIRE_SIZE)) u_round_encode (
        .mag_i  (s1_mag_q),
        .code_o (code_d)
    );

    assign pos_mag = {1'b0, s2_code_q};

    always_comb begin
        posit_d = s2_sign_q ? (~pos_mag + 4'd1) : pos_mag;
        if (s2_nar_q)       posit_d = POSIT_4_0_NAR;
        else if (s2_zero_q) posit_d = POSIT_4_0_ZERO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nar_acc_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_sow_q   <= 1'b0;
            s1_eow_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_code_q  <= '0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_sow_q   <= 1'b0;
            s2_eow_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_posit_q <= POSIT_4_0_ZERO;
            s3_nar_q   <= 1'b0;
            s3_sow_q   <= 1'b0;
            s3_eow_q   <= 1'b0;
        end else if (process_en) begin
            if (accept) begin
                nar_acc_q <= nar_acc_d;
            end
            // Non-eow beats only feed the sticky NaR when ONLY_EOW is set.
            s1_valid_q <= accept & (eow_i | ~ONLY_EOW);
            s1_mag_q   <= mag_d;
            s1_sign_q  <= sign_i;
            s1_zero_q  <= zero_i;
            s1_nar_q   <= nar_cap_d;
            s1_sow_q   <= sow_i;
            s1_eow_q   <= eow_i;

            s2_valid_q <= s1_valid_q;
            s2_code_q  <= code_d;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= s1_zero_q;
            s2_nar_q   <= s1_nar_q;
            s2_sow_q   <= s1_sow_q;
            s2_eow_q   <= s1_eow_q;

            s3_valid_q <= s2_valid_q;
            s3_posit_q <= posit_d;
            s3_nar_q   <= s2_nar_q;
            s3_sow_q   <= s2_sow_q & s2_valid_q;
            s3_eow_q   <= s2_eow_q & s2_valid_q;
        end
    end

    assign rts_o   = s3_valid_q;
    assign posit_o = s3_posit_q;
    assign NaR_o   = s3_nar_q;
    assign sow_o   = s3_sow_q;
    assign eow_o   = s3_eow_q;
    assign zero_o  = (s3_posit_q == 4'b0000);
    assign sign_o  = s3_posit_q[3];

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// tb/tb_quire_to_posit_4_0.sv - directed-vector bench for quire_to_posit_4_0
module tb_quire_to_posit_4_0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0;
    logic [19:0] data_i = '0;
    logic        sign_i = 1'b0, zero_i = 1'b0, nar_i = 1'b0;
    logic        rtr1 = 1'b1, rtr0 = 1'b1;

    logic       a_rtr_o, a_rts_o, a_sow_o, a_eow_o, a_nar_o, a_zero_o, a_sign_o;
    logic [3:0] a_posit_o;
    logic       b_rtr_o, b_rts_o, b_sow_o, b_eow_o, b_nar_o, b_zero_o, b_sign_o;
    logic [3:0] b_posit_o;

    always #5 clk = ~clk;

    quire_to_posit_4_0 #(.ONLY_EOW(1'b1), .QUIRE_SIZE(20)) dut (
        .clk(clk), .rst(rst), .rts_i(rts_i), .rtr_o(a_rtr_o), .sow_i(sow_i), .eow_i(eow_i),
        .data_i(data_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i), .rtr_i(rtr1),
        .rts_o(a_rts_o), .sow_o(a_sow_o), .eow_o(a_eow_o), .posit_o(a_posit_o),
        .NaR_o(a_nar_o), .zero_o(a_zero_o), .sign_o(a_sign_o)
    );

    quire_to_posit_4_0 #(.ONLY_EOW(1'b0), .QUIRE_SIZE(20)) dut_all (
        .clk(clk), .rst(rst), .rts_i(rts_i), .rtr_o(b_rtr_o), .sow_i(sow_i), .eow_i(eow_i),
        .data_i(data_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i), .rtr_i(rtr0),
        .rts_o(b_rts_o), .sow_o(b_sow_o), .eow_o(b_eow_o), .posit_o(b_posit_o),
        .NaR_o(b_nar_o), .zero_o(b_zero_o), .sign_o(b_sign_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [19:0] d, input logic sow, input logic eow, input logic nar);
        data_i = d;
        sign_i = d[19];
        zero_i = (d == 20'h0);
        sow_i  = sow;
        eow_i  = eow;
        nar_i  = nar;
    endtask

    task automatic send_beat(input logic [19:0] d, input logic sow, input logic eow, input logic nar);
        set_beat(d, sow, eow, nar);
        rts_i = 1'b1;
        step();
        rts_i = 1'b0;
    endtask

    task automatic single(input string tag, input logic [19:0] d, input logic [3:0] exp);
        int lat;
        send_beat(d, 1'b1, 1'b1, 1'b0);
        lat = 1;
        while (!a_rts_o && lat < 10) begin
            step();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 3);
        check_eq(tag, a_posit_o, exp);
        check_eq({tag, "_eow"}, a_eow_o, 1);
        if (d == 20'h0) begin
            check_eq({tag, "_zero_o"}, a_zero_o, 1);
            check_eq({tag, "_sign_o"}, a_sign_o, 0);
        end
        step();
    endtask

    logic [4:0] a_q[$];
    logic [4:0] b_q[$];
    logic [3:0] held;
    bit         hold_v = 1'b0;

    always @(negedge clk) begin
        if (a_rts_o) a_q.push_back({a_nar_o, a_posit_o});
        if (b_rts_o && rtr0) b_q.push_back({b_nar_o, b_posit_o});
        if (b_rts_o && !rtr0) begin
            check_eq("stall_rtr_o", b_rtr_o, 0);
            if (hold_v) check_eq("stall_posit_hold", b_posit_o, held);
            held   = b_posit_o;
            hold_v = 1'b1;
        end else begin
            hold_v = 1'b0;
        end
    end

    logic [19:0] sv_d[16];
    logic [3:0]  sv_e[16];
    logic [19:0] bp_d[10];
    logic [3:0]  bp_e[10];

    initial begin
        sv_d = '{20'h00001, 20'h00006, 20'h0000A, 20'h0000E, 20'h00014, 20'h0001C,
                 20'h00030, 20'h7FFFF, 20'hFFFEC, 20'hFFFFF, 20'h80000, 20'h00005,
                 20'h0000B, 20'h00015, 20'h00031, 20'h00000};
        sv_e = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0110,
                 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b1001, 4'b0001,
                 4'b0011, 4'b0101, 4'b0111, 4'b0000};
        bp_d = '{20'h00002, 20'h00007, 20'h0000B, 20'h00010, 20'h00016,
                 20'h00020, 20'h00040, 20'hFFFF9, 20'h00000, 20'hFFFF0};
        bp_e = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                 4'b0110, 4'b0111, 4'b1110, 4'b0000, 4'b1100};

        repeat (3) step();
        check_eq("rst_rts_o", a_rts_o, 0);
        check_eq("rst_posit_o", a_posit_o, 4'b0000);
        check_eq("rst_zero_o", a_zero_o, 1);
        check_eq("rst_sign_o", a_sign_o, 0);
        check_eq("rst_nar_o", a_nar_o, 0);
        check_eq("rst_sow_eow", {a_sow_o, a_eow_o}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            single($sformatf("single_%05h", sv_d[i]), sv_d[i], sv_e[i]);
        end

        a_q.delete();
        send_beat(20'h00010, 1'b1, 1'b0, 1'b0);
        send_beat(20'h00010, 1'b0, 1'b0, 1'b1);
        send_beat(20'h00010, 1'b0, 1'b0, 1'b0);
        send_beat(20'h00010, 1'b0, 1'b1, 1'b0);
        repeat (6) step();
        check_eq("nar_win_count", a_q.size(), 1);
        if (a_q.size() > 0) check_eq("nar_win_result", a_q[0], 5'h18);

        a_q.delete();
        send_beat(20'h00010, 1'b1, 1'b0, 1'b0);
        send_beat(20'h00010, 1'b0, 1'b0, 1'b0);
        send_beat(20'h00010, 1'b0, 1'b0, 1'b0);
        send_beat(20'h00006, 1'b0, 1'b1, 1'b0);
        repeat (6) step();
        check_eq("clean_win_count", a_q.size(), 1);
        if (a_q.size() > 0) check_eq("clean_win_result", a_q[0], 5'h02);

        b_q.delete();
        begin
            int i;
            int cyc;
            logic ok;
            i = 0;
            cyc = 0;
            while (i < 10 && cyc < 100) begin
                rtr0 = !(cyc >= 4 && cyc <= 8);
                set_beat(bp_d[i], i == 0, i == 9, 1'b0);
                rts_i = 1'b1;
                #1;
                ok = b_rtr_o;
                @(posedge clk);
                #1;
                if (ok) i++;
                cyc++;
            end
            check_eq("bp_all_sent", i, 10);
        end
        rts_i = 1'b0;
        rtr0  = 1'b1;
        repeat (8) step();
        check_eq("bp_count", b_q.size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < b_q.size()) check_eq($sformatf("bp_out_%0d", k), b_q[k], {1'b0, bp_e[k]});
        end

        a_q.delete();
        send_beat(20'h00010, 1'b1, 1'b0, 1'b1);
        send_beat(20'h00010, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        check_eq("midrst_rts_o", a_rts_o, 0);
        check_eq("midrst_posit_o", a_posit_o, 4'b0000);
        check_eq("midrst_nar_o", a_nar_o, 0);
        rst = 1'b0;
        repeat (5) step();
        check_eq("midrst_no_output", a_q.size(), 0);
        send_beat(20'h00010, 1'b1, 1'b0, 1'b0);
        send_beat(20'h00010, 1'b0, 1'b1, 1'b0);
        repeat (6) step();
        check_eq("postrst_count", a_q.size(), 1);
        if (a_q.size() > 0) check_eq("postrst_result", a_q[0], 5'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quire_to_posit_4_0.md
# quire_to_posit_4_0

Converts the 20-bit two's-complement quire emitted by the posit<4,0> accumulator into a rounded 4-bit posit<4,0> result. It sits directly downstream of the accumulator stage and uses the same sow/eow framed rts/rtr stream. It tracks a sticky NaR across each sow..eow window. With the default configuration it emits exactly one posit per window, on the eow beat.

## Interface
- ONLY_EOW, 1: 1 = only eow beats produce output beats, other beats are consumed and dropped; 0 = every beat produces an output.
- QUIRE_SIZE, 20: quire width. Fixed-point value = data_i / 16 (4 fraction bits). Must be ≥ 7.

Ports:
- clk  in  1  sole clock; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- rts_i  in  1  upstream beat valid
- rtr_o  out  1  ready to receive; equals rtr_i | ~rts_o (combinational)
- sow_i  in  1  start of window
- eow_i  in  1  end of window
- data_i  in  QUIRE_SIZE  quire, two's complement
- sign_i  in  1  quire sign; must equal data_i[MSB]; used for the result sign
- zero_i  in  1  quire is zero; forces the zero result
- NaR_i  in  1  beat is NaR
- rtr_i  in  1  downstream ready
- rts_o  out  1  output beat valid
- sow_o, eow_o  out  1  framing flags, delayed with the data
- posit_o  out  4  posit<4,0> result
- NaR_o  out  1  result is NaR (posit_o = 4'b1000)
- zero_o  out  1  posit_o == 0 (combinational)
- sign_o  out  1  posit_o[3] (combinational)

## Operation
- Transfer: a beat is accepted when rts_i & rtr_o. Stage enable process_en = rtr_i | ~rts_o; all stages advance together or hold.
- Stage 1 (register):
  - Capture the absolute magnitude m = |data_i| as QUIRE_SIZE-bit unsigned; −2^(QUIRE_SIZE−1) maps to 2^(QUIRE_SIZE−1).
  - Capture sign_i, zero_i, sow_i and eow_i.
  - Sticky NaR: on sow_i, nar_acc <= NaR_i; otherwise nar_acc <= nar_acc | NaR_i. The captured NaR value is NaR_i | (~sow_i & nar_acc). A beat with sow_i and eow_i together forms a one-beat window.
  - With ONLY_EOW=1, an accepted beat without eow_i updates nar_acc only and becomes a bubble.
- Stage 2 (register): classify m into a 3-bit magnitude code, ties to even encoding:
  - m=0: 000
  - 1..5: 001
  - 6..10: 010
  - 11..13: 011
  - 14..20: 100
  - 21..27: 101
  - 28..48: 110
  - ≥49: 111
  - Consequences: nonzero values never round to zero (minpos 1/4); values above 4 saturate to maxpos.
- Stage 3 (register):
  - NaR gives 1000.
  - Otherwise zero_i gives 0000.
  - Otherwise the result is {0,code}, two's-complement negated over 4 bits when the sign is set.
  - NaR takes precedence over zero.
- Bubbles: a stage with no valid beat clears its valid bit when process_en is high.

## Timing
- Latency: 3 cycles from acceptance to rts_o with no stall.
- Throughput: 1 beat/cycle.
- Reset values: rts_o=0, posit_o=0000, sow_o=0, eow_o=0, NaR_o=0, nar_acc=0. Hence zero_o=1 and sign_o=0 during reset.
- Stall: while rts_o & ~rtr_i, every output stays stable and rtr_o=0. No beat is lost or duplicated.
- Reset mid-window: discards in-flight beats and the sticky state. The next window must begin with sow_i.
- An eow beat without a preceding sow keeps accumulating NaR from the last sow; it is not an error.

## Structure
- Add to package posit_defines:
  - the magnitude thresholds 6, 11, 14, 21, 28, 49 as constants;
  - the NaR pattern 4'b1000;
  - the constant QUIRE_FRAC_BITS_4_0 = 4.
- Sub-module posit_4_0_round_encode: combinational, unsigned magnitude in, 3-bit code out. It is reused by future posit<4,0> converters.

## Test plan
- Single-beat windows (sow=eow=1, ONLY_EOW=1, rtr_i=1):
  - data_i 0x00001 -> 0001
  - 0x00006 -> 0010
  - 0x0000A -> 0010
  - 0x0000E -> 0100
  - 0x00014 -> 0100
  - 0x0001C -> 0110
  - 0x00030 -> 0110
  - 0x7FFFF -> 0111
  - each appears 3 cycles after acceptance
- Negative values:
  - 0xFFFEC (−1.25) -> 1100
  - 0xFFFFF (−1/16) -> 1111
  - 0x80000 -> 1001
- Zero: zero_i=1, data 0 -> 0000 with zero_o=1 and sign_o=0.
- Window of 4 beats, NaR_i=1 on beat 2 only -> exactly one output at eow, posit_o=1000, NaR_o=1. The following clean window -> a non-NaR result.
- Backpressure: rtr_i=0 for 5 cycles during a 10-beat stream with ONLY_EOW=0.
  - rtr_o=0 while rts_o is held.
  - Output values are held stable.
  - All 10 results arrive in order, with none dropped.
- Assert rst mid-window -> rts_o=0 and posit_o=0000 the next cycle. A subsequent window starting with sow converts correctly, with no stale NaR.
